// File: rtl/rx_controller_ear_pkg.sv
// Shared frame definitions for the serial link: FSM states, framing patterns,
// header field positions and the CRC-8 step used by both ends of the link.
package rx_controller_ear_pkg;

    typedef enum logic [2:0] {
        S_HUNT   = 3'd0,
        S_HEADER = 3'd1,
        S_DATA   = 3'd2,
        S_CRC    = 3'd3,
        S_DONE   = 3'd4
    } rx_state_t;

    localparam logic [15:0] PREAMBLE_PATTERN = 16'hAAAA;
    localparam logic [7:0]  SFD_PATTERN      = 8'hAB;
    // Hunt window target: the last preamble byte followed by the SFD.
    localparam logic [15:0] HUNT_PATTERN     = {PREAMBLE_PATTERN[7:0], SFD_PATTERN};

    localparam int DEST_MSB = 7;
    localparam int DEST_LSB = 6;
    localparam int SRC_MSB  = 5;
    localparam int SRC_LSB  = 4;
    localparam int LEN_MSB  = 3;
    localparam int LEN_LSB  = 0;

    localparam logic [1:0] BROADCAST_ID = 2'b11;

    localparam logic [7:0] CRC8_POLY = 8'h07;

    // One MSB-first step of the CRC-8 LFSR (x^8 + x^2 + x + 1, init 0).
    function automatic logic [7:0] crc8_next(input logic [7:0] crc, input logic din);
        logic fb;
        fb = crc[7] ^ din;
        return {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/rx_controller_ear_crc8_serial.sv
// Bit-serial CRC-8 engine: clears on clr, advances one bit per clk while en is high.
module crc8_serial
    import rx_controller_ear_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       en,
    input  logic       data_in,
    output logic [7:0] crc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc <= 8'h00;
        end else if (clr) begin
            crc <= 8'h00;
        end else if (en) begin
            crc <= crc8_next(crc, data_in);
        end
    end

endmodule

// File: rtl/rx_controller_ear.sv
// Serial frame receiver: hunts for preamble+SFD, collects header, payload and CRC,
// then publishes the packet only when the CRC matches and the frame is addressed to us.
module rx_controller_ear
    import rx_controller_ear_pkg::*;
#(
    parameter logic [1:0] MY_ID = 2'b00
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         rx_line,
    output logic [135:0] rx_packet,
    output logic         rx_valid,
    output logic         rx_crc_err,
    output logic         rx_busy
);

    rx_state_t state, next_state;

    logic [7:0]   cnt;
    logic [15:0]  window;
    logic [15:0]  hunt_window;
    logic [7:0]   header;
    logic [127:0] payload;
    logic [7:0]   crc_rx;
    logic [7:0]   crc_full;
    logic [7:0]   crc_calc;
    logic [7:0]   data_last;
    logic [6:0]   data_idx;
    logic [1:0]   dest;
    logic         crc_ok;
    logic         addr_ok;
    logic         frame_end;

    assign hunt_window = {window[14:0], rx_line};
    // (length+1)*8-1 is length in bits [6:3] with the low three bits all ones.
    assign data_last   = {1'b0, header[LEN_MSB:LEN_LSB], 3'b111};
    assign data_idx    = 7'd127 - cnt[6:0];
    assign crc_full    = {crc_rx[6:0], rx_line};
    assign crc_ok      = (crc_full == crc_calc);
    assign dest        = header[DEST_MSB:DEST_LSB];
    assign addr_ok     = (dest == MY_ID) || (dest == BROADCAST_ID);
    assign frame_end   = (state == S_CRC) && (cnt == 8'd7);

    crc8_serial u_crc (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (state == S_HUNT),
        .en      (state == S_DATA),
        .data_in (rx_line),
        .crc     (crc_calc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_HUNT;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_HUNT:   if (hunt_window == HUNT_PATTERN) next_state = S_HEADER;
            S_HEADER: if (cnt == 8'd7) next_state = S_DATA;
            S_DATA:   if (cnt == data_last) next_state = S_CRC;
            S_CRC:    if (cnt == 8'd7) next_state = S_DONE;
            S_DONE:   next_state = S_HUNT;
            default:  next_state = S_HUNT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= 8'h00;
            window     <= 16'h0000;
            header     <= 8'h00;
            payload    <= '0;
            crc_rx     <= 8'h00;
            rx_packet  <= '0;
            rx_valid   <= 1'b0;
            rx_crc_err <= 1'b0;
            rx_busy    <= 1'b0;
        end else begin
            if ((next_state != state) || (state == S_HUNT) || (state == S_DONE)) begin
                cnt <= 8'h00;
            end else begin
                cnt <= cnt + 8'd1;
            end

            // S_DONE keeps shifting so a back-to-back preamble loses no bits.
            if ((state == S_HUNT) || (state == S_DONE)) begin
                window <= hunt_window;
            end else begin
                window <= 16'h0000;
            end

            if (state == S_HEADER) begin
                header  <= {header[6:0], rx_line};
                payload <= '0;
            end
            if (state == S_DATA) begin
                payload[data_idx] <= rx_line;
            end
            if (state == S_CRC) begin
                crc_rx <= crc_full;
            end

            rx_valid   <= frame_end && crc_ok && addr_ok;
            rx_crc_err <= frame_end && !crc_ok;
            if (frame_end && crc_ok && addr_ok) begin
                rx_packet <= {header, payload};
            end
            rx_busy <= (next_state != S_HUNT);
        end
    end

endmodule

// File: tb/tb_rx_controller_ear.sv
// Bench for rx_controller_ear: a serial frame generator drives two receivers
// (MY_ID 0 and 1) on one line; a frame-level model predicts pulses and packets.
module tb_rx_controller_ear;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         rx_line = 1'b0;
    logic [135:0] pkt0, pkt1;
    logic         valid0, valid1, err0, err1, busy0, busy1;

    rx_controller_ear dut0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_line    (rx_line),
        .rx_packet  (pkt0),
        .rx_valid   (valid0),
        .rx_crc_err (err0),
        .rx_busy    (busy0)
    );

    rx_controller_ear #(.MY_ID(2'b01)) dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_line    (rx_line),
        .rx_packet  (pkt1),
        .rx_valid   (valid1),
        .rx_crc_err (err1),
        .rx_busy    (busy1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Observed pulse counts, last pulse cycle, and packet changes without rx_valid.
    int v0 = 0, v1 = 0, e0 = 0, e1 = 0, pcyc0 = 0, pcyc1 = 0, g0 = 0, g1 = 0;
    logic [135:0] prev0 = '0, prev1 = '0;

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev0 = '0;
            prev1 = '0;
        end else begin
            if (valid0) begin v0++; pcyc0 = cyc; end
            if (err0)   begin e0++; pcyc0 = cyc; end
            if (valid1) begin v1++; pcyc1 = cyc; end
            if (err1)   begin e1++; pcyc1 = cyc; end
            if (pkt0 !== prev0 && !valid0) g0++;
            if (pkt1 !== prev1 && !valid1) g1++;
            prev0 = pkt0;
            prev1 = pkt1;
        end
    end

    // Reference model state.
    int exp_v0 = 0, exp_v1 = 0, exp_e0 = 0, exp_e1 = 0, last_cyc = 0;
    bit exp_pulse0 = 0, exp_pulse1 = 0;
    logic [135:0] exp_pkt0 = '0, exp_pkt1 = '0;

    task automatic chk(input string tag, input logic [135:0] obs, input logic [135:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // CRC as the remainder of M(x)*x^8 divided by x^8+x^2+x+1, by long division.
    function automatic logic [7:0] crc_ref(input logic [127:0] pl, input int nbytes);
        logic [135:0] m;
        int n;
        m = '0;
        n = nbytes * 8 + 8;
        for (int k = 0; k < nbytes * 8; k++) m[n - 1 - k] = pl[127 - k];
        for (int i = n - 1; i >= 8; i--) begin
            if (m[i]) m[i -: 9] = m[i -: 9] ^ 9'h107;
        end
        return m[7:0];
    endfunction

    task automatic send_bit(input logic b);
        rx_line = b;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) send_bit(1'b0);
    endtask

    task automatic send_frame(input logic [7:0] hdr, input logic [127:0] pl, input int pre_len,
                              input int zeros, input bit corrupt, input int abort_bits,
                              input int idle_after);
        bit q[$];
        int nbytes, nb, sfd_end;
        logic [127:0] ones, plm;
        logic [7:0] sfd, c;
        bit ok, a0, a1;
        nbytes = int'(hdr[3:0]) + 1;
        nb = nbytes * 8;
        ones = '1;
        plm = pl & ~(ones >> nb);
        c = crc_ref(plm, nbytes);
        sfd = 8'hAB;
        for (int i = 0; i < zeros; i++) q.push_back(1'b0);
        for (int i = pre_len - 1; i >= 0; i--) q.push_back(i % 2 == 1);
        for (int i = 7; i >= 0; i--) q.push_back(sfd[i]);
        sfd_end = q.size() - 1;
        for (int i = 7; i >= 0; i--) q.push_back(hdr[i]);
        for (int k = 0; k < nb; k++) q.push_back(plm[127 - k] ^ (corrupt && k == 0));
        for (int i = 7; i >= 0; i--) q.push_back(c[i]);

        for (int i = 0; i < q.size(); i++) begin
            if (i == abort_bits) begin
                rx_line = q[i];
                #1 rst_n = 1'b0;
                #1;
                chk("rst/pkt0", pkt0, '0);
                chk("rst/pkt1", pkt1, '0);
                chk("rst/busy0", 136'(busy0), 136'(0));
                chk("rst/valid0", 136'(valid0), 136'(0));
                exp_pkt0 = '0;
                exp_pkt1 = '0;
                exp_pulse0 = 0;
                exp_pulse1 = 0;
                #1 rst_n = 1'b1;
                return;
            end
            send_bit(q[i]);
            if (i == sfd_end) begin
                chk("sfd/busy0", 136'(busy0), 136'(1));
                chk("sfd/busy1", 136'(busy1), 136'(1));
            end
        end
        last_cyc = cyc;

        ok = !corrupt;
        a0 = (hdr[7:6] == 2'b00) || (hdr[7:6] == 2'b11);
        a1 = (hdr[7:6] == 2'b01) || (hdr[7:6] == 2'b11);
        if (ok && a0) begin exp_v0++; exp_pkt0 = {hdr, plm}; end
        if (ok && a1) begin exp_v1++; exp_pkt1 = {hdr, plm}; end
        if (!ok) begin exp_e0++; exp_e1++; end
        exp_pulse0 = ok ? a0 : 1'b1;
        exp_pulse1 = ok ? a1 : 1'b1;
        idle(idle_after);
    endtask

    task automatic check_frame(input string tag);
        chk({tag, "/valid0"}, 136'(v0), 136'(exp_v0));
        chk({tag, "/valid1"}, 136'(v1), 136'(exp_v1));
        chk({tag, "/err0"}, 136'(e0), 136'(exp_e0));
        chk({tag, "/err1"}, 136'(e1), 136'(exp_e1));
        chk({tag, "/pkt0"}, pkt0, exp_pkt0);
        chk({tag, "/pkt1"}, pkt1, exp_pkt1);
        chk({tag, "/busy0"}, 136'(busy0), 136'(0));
        if (exp_pulse0) chk({tag, "/lat0"}, 136'(pcyc0), 136'(last_cyc));
        if (exp_pulse1) chk({tag, "/lat1"}, 136'(pcyc1), 136'(last_cyc));
    endtask

    initial begin
        #12;
        chk("reset/pkt0", pkt0, '0);
        chk("reset/valid0", 136'(valid0), 136'(0));
        chk("reset/err0", 136'(err0), 136'(0));
        chk("reset/busy1", 136'(busy1), 136'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        idle(4);

        send_frame(8'h00, {8'h5A, 120'h0}, 16, 0, 0, -1, 2);
        check_frame("good");
        chk("good/literal", pkt0, {8'h00, 8'h5A, 120'h0});

        send_frame(8'h0F, 128'h000102030405060708090A0B0C0D0E0F, 16, 0, 0, -1, 2);
        check_frame("maxlen");
        chk("maxlen/literal", pkt0, {8'h0F, 128'h000102030405060708090A0B0C0D0E0F});

        send_frame(8'h01, {16'hC3E7, 112'h0}, 16, 0, 1, -1, 2);
        check_frame("crcerr");

        send_frame(8'h81, {16'h1234, 112'h0}, 16, 0, 0, -1, 2);
        check_frame("dest10");
        send_frame(8'hC1, {16'h5678, 112'h0}, 16, 0, 0, -1, 2);
        check_frame("dest11");
        send_frame(8'h52, {24'h9ABCDE, 104'h0}, 16, 0, 0, -1, 2);
        check_frame("dest01");

        send_frame(8'h00, {8'hE1, 120'h0}, 8, 3, 0, -1, 2);
        check_frame("pre8");

        send_frame(8'h03, {32'hAAAAAAAB, 96'h0}, 16, 0, 0, -1, 2);
        check_frame("midpre");

        send_frame(8'hC0, {8'h11, 120'h0}, 8, 0, 0, -1, 0);
        send_frame(8'hC1, {16'h2233, 112'h0}, 8, 0, 0, -1, 2);
        check_frame("b2b");

        send_frame(8'h00, {32'hFFFFFFFF, 96'h0}, 16, 0, 0, 36, 0);
        idle(3);
        check_frame("abort");
        send_frame(8'h00, {8'h3C, 120'h0}, 16, 0, 0, -1, 2);
        check_frame("clean");

        for (int n = 0; n < 100; n++) begin
            logic [7:0] hdr;
            logic [127:0] pl;
            hdr = 8'($urandom_range(0, 255));
            pl = {$urandom, $urandom, $urandom, $urandom};
            send_frame(hdr, pl, int'($urandom_range(8, 16)), int'($urandom_range(0, 3)), 0, -1, 1);
            check_frame("loop");
        end

        chk("glitch0", 136'(g0), 136'(0));
        chk("glitch1", 136'(g1), 136'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rx_controller_ear.md
RX_CONTROLLER_EAR -- requirements
Module: rx_controller_ear

Interface
REQ-001 SHALL have parameter MY_ID, default 2'b00: node address used by the destination filter.
REQ-002 SHALL have port clk  input  1  the single clock, rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port rx_line  input  1  serial line, one bit per clk, synchronous to clk.
REQ-005 SHALL have port rx_packet  output  136  {header[7:0], payload[127:0]}; payload MSB-aligned, unused LSBs 0.
REQ-006 SHALL have port rx_valid  output  1  one-clk pulse: the packet passed CRC and the filter.
REQ-007 SHALL have port rx_crc_err  output  1  one-clk pulse: CRC mismatch.
REQ-008 SHALL have port rx_busy  output  1  high from SFD match until the frame ends.

Function
REQ-009 SHALL sample rx_line on every rising clk edge; no oversampling.
REQ-010 SHALL implement the states S_HUNT, S_HEADER, S_DATA, S_CRC and S_DONE.
REQ-011 S_HUNT SHALL shift bits into a 16-bit window and move to S_HEADER when window == 16'hAAAB (last 8 preamble bits plus SFD 8'hAB).
REQ-012 SHALL accept a preamble of 8 to 16 bits; extra leading 0s are ignored.
REQ-013 S_HEADER SHALL collect 8 bits MSB first; header fields: [7:6] dest_id, [5:4] src_id, [3:0] length.
REQ-014 S_DATA SHALL collect (length+1)*8 bits MSB first (1..16 bytes), shifting into payload from bit 127 downward.
REQ-015 The data bit counter SHALL be 8 bits and terminate at ((length+1)*8)-1.
REQ-016 S_CRC SHALL collect 8 received CRC bits MSB first.
REQ-017 CRC SHALL cover data bits only, not preamble/SFD/header/CRC.
REQ-018 CRC data_in SHALL be driven combinationally from rx_line.
REQ-019 CRC enable SHALL be driven combinationally as (state==S_DATA), so the calculated CRC is final when S_CRC is entered.
REQ-020 The CRC engine SHALL be cleared while in S_HUNT.
REQ-021 After the 8th CRC bit, SHALL enter S_DONE for one cycle, then return to S_HUNT.
REQ-022 S_DONE comparison, CRC equal and dest_id==MY_ID or 2'b11: SHALL pulse rx_valid and load rx_packet.
REQ-023 S_DONE comparison, CRC mismatch: SHALL pulse rx_crc_err and leave rx_packet unchanged.
REQ-024 S_DONE comparison, CRC equal but dest_id not matched: SHALL drop the frame silently with no pulse.
REQ-025 Latency: rx_valid/rx_crc_err SHALL be asserted in the cycle after the edge sampling the last CRC bit, for exactly one clk.
REQ-026 rx_packet SHALL hold its last good value until the next valid frame; it SHALL never show a partial frame.
REQ-027 rx_busy SHALL rise the cycle after the SFD match and fall on S_DONE exit.
REQ-028 A new preamble arriving mid-frame SHALL NOT resynchronise; resync happens only in S_HUNT.
REQ-029 Back-to-back frames SHALL be accepted with 0 idle bits after S_DONE, provided at least 8 preamble bits follow.

Reset
REQ-030 rst_n low SHALL force state=S_HUNT, counters=0, window=0, rx_packet=0, rx_valid=0, rx_crc_err=0, rx_busy=0, and clear the CRC, immediately and regardless of clk.
REQ-031 Reset asserted mid-frame SHALL discard the frame; no pulse SHALL follow deassertion.

Structure
REQ-032 A shared package SHALL hold the state encodings, PREAMBLE_PATTERN 16'hAAAA, SFD_PATTERN 8'hAB, the header field positions and the broadcast id 2'b11, shared with the transmitter.
REQ-033 SHALL instantiate exactly one sub-module, crc8_serial (the existing serial CRC-8), as the CRC engine.

Verification
REQ-034 Scenario, good frame: 16'hAAAA, 8'hAB, header 8'h00, payload 8'h5A, correct CRC -> one rx_valid pulse and rx_packet = {8'h00, 8'h5A, 120'h0}.
REQ-035 Scenario, maximum length: header 8'h0F with 16 bytes 8'h00..8'h0F -> rx_valid and payload 128'h000102030405060708090A0B0C0D0E0F.
REQ-036 Scenario, bit error: first data bit inverted (transmitter test_mode=1) -> rx_crc_err pulse, no rx_valid, rx_packet unchanged.
REQ-037 Scenario, address filter: MY_ID=2'b01; dest 2'b10 -> no pulses; dest 2'b11 -> rx_valid.
REQ-038 Scenario, reset mid-data: rst_n low during the 5th data bit, then a clean frame -> only the clean frame yields rx_valid.
REQ-039 Scenario, loopback: transmitter tx_line wired to rx_line, 100 random packets -> rx_packet equals tx_packet every time and rx_crc_err never asserts.
